// File: rtl/rv32_irq_ctrl_if.sv
// Register-port bundle of the interrupt controller: word-addressed
// read/write strobes with registered read data.
interface rv32_irq_ctrl_if;
  logic [5:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [31:0] reg_rdata;

  modport master (output reg_addr, reg_wdata, reg_we, reg_re, input reg_rdata);
  modport slave  (input reg_addr, reg_wdata, reg_we, reg_re, output reg_rdata);
endinterface

// File: rtl/rv32_irq_ctrl.sv
// Prioritised interrupt controller for an RV32 core: per-source gateway,
// claim/complete handshake over a small register port, registered irq_o.
module rv32_irq_src #(
  parameter int PRIO_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              src_i,
  input  logic              mode_i,
  input  logic              prio_we_i,
  input  logic [PRIO_W-1:0] prio_wdata_i,
  input  logic              claim_i,
  input  logic              complete_i,
  output logic              pending_o,
  output logic              in_service_o,
  output logic [PRIO_W-1:0] prio_o
);
  logic              prev_q, pend_q, pend_d, svc_q, svc_d, gw_set;
  logic [PRIO_W-1:0] prio_q;

  // Requests are dropped outright while in service; edges are not queued.
  assign gw_set = ~svc_q & src_i & (~mode_i | ~prev_q);

  always_comb begin
    pend_d = pend_q | gw_set;
    svc_d  = svc_q;
    if (complete_i) svc_d = 1'b0;
    if (claim_i) begin
      pend_d = 1'b0;
      svc_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
      svc_q  <= 1'b0;
      prio_q <= '0;
    end else begin
      prev_q <= src_i;
      pend_q <= pend_d;
      svc_q  <= svc_d;
      if (prio_we_i) prio_q <= prio_wdata_i;
    end
  end

  assign pending_o    = pend_q;
  assign in_service_o = svc_q;
  assign prio_o       = prio_q;
endmodule

module rv32_irq_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_i,
  rv32_irq_ctrl_if.slave     bus,
  output logic               irq_o
);
  localparam logic [5:0] A_PEND  = 6'h00;
  localparam logic [5:0] A_EN    = 6'h01;
  localparam logic [5:0] A_MODE  = 6'h02;
  localparam logic [5:0] A_THR   = 6'h03;
  localparam logic [5:0] A_CLAIM = 6'h04;

  logic [NUM_SRC-1:0]             enable_q, mode_q, pending, in_svc, cand;
  logic [NUM_SRC-1:0]             win_oh, claim_vec, cmp_vec, prio_we;
  logic [NUM_SRC-1:0][PRIO_W-1:0] prio;
  logic [PRIO_W-1:0]              thresh_q, best;
  logic [31:0]                    rdata_q, rd_val;
  logic [4:0]                     win_id;
  logic                           irq_q, claim_rd, cmp_wr;

  assign claim_rd = bus.reg_re & (bus.reg_addr == A_CLAIM);
  assign cmp_wr   = bus.reg_we & (bus.reg_addr == A_CLAIM);

  // Comparing wdata against each ID rejects 0 and out-of-range IDs for free.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign cand[g]      = pending[g] & enable_q[g] & (prio[g] > thresh_q);
    assign prio_we[g]   = bus.reg_we & (bus.reg_addr == 6'(8 + g));
    assign claim_vec[g] = claim_rd & win_oh[g];
    assign cmp_vec[g]   = cmp_wr & (bus.reg_wdata == 32'(g + 1)) & in_svc[g] & ~claim_vec[g];

    rv32_irq_src #(.PRIO_W(PRIO_W)) u_src (
      .clk          (clk),
      .rst_n        (rst_n),
      .src_i        (src_i[g]),
      .mode_i       (mode_q[g]),
      .prio_we_i    (prio_we[g]),
      .prio_wdata_i (bus.reg_wdata[PRIO_W-1:0]),
      .claim_i      (claim_vec[g]),
      .complete_i   (cmp_vec[g]),
      .pending_o    (pending[g]),
      .in_service_o (in_svc[g]),
      .prio_o       (prio[g])
    );
  end

  // Strict '>' keeps the lowest index on priority ties.
  always_comb begin
    win_oh = '0;
    win_id = '0;
    best   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cand[i] && prio[i] > best) begin
        best      = prio[i];
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_id    = 5'(i + 1);
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (bus.reg_addr)
      A_PEND:  rd_val[NUM_SRC-1:0] = pending;
      A_EN:    rd_val[NUM_SRC-1:0] = enable_q;
      A_MODE:  rd_val[NUM_SRC-1:0] = mode_q;
      A_THR:   rd_val[PRIO_W-1:0]  = thresh_q;
      A_CLAIM: rd_val[4:0]         = win_id;
      default: begin
        for (int i = 0; i < NUM_SRC; i++)
          if (bus.reg_addr == 6'(8 + i)) rd_val[PRIO_W-1:0] = prio[i];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q <= '0;
      mode_q   <= '0;
      thresh_q <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= |cand;
      if (bus.reg_re) rdata_q <= rd_val;
      if (bus.reg_we) begin
        case (bus.reg_addr)
          A_EN:    enable_q <= bus.reg_wdata[NUM_SRC-1:0];
          A_MODE:  mode_q   <= bus.reg_wdata[NUM_SRC-1:0];
          A_THR:   thresh_q <= bus.reg_wdata[PRIO_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign bus.reg_rdata = rdata_q;
  assign irq_o         = irq_q;
endmodule
